// File: rtl/serial_flag_unit_if.sv
// ============================================================================
// Module      : serial_flag_unit_if
// Description : Request/result bundle for serial_flag_unit. The overflow
//               signal exists only when SERIAL_FLAG_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_flag_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_cmp;
    logic             busy;
    logic             done;
    logic             zero;
    logic             negative;
`ifdef SERIAL_FLAG_OVF_EN
    logic             overflow;
`endif

`ifdef SERIAL_FLAG_OVF_EN
    modport master (output start, a, b, signed_cmp,
                    input  busy, done, zero, negative, overflow);
    modport slave  (input  start, a, b, signed_cmp,
                    output busy, done, zero, negative, overflow);
`else
    modport master (output start, a, b, signed_cmp,
                    input  busy, done, zero, negative);
    modport slave  (input  start, a, b, signed_cmp,
                    output busy, done, zero, negative);
`endif

endinterface

`default_nettype wire

// File: rtl/serial_flag_unit.sv
// ============================================================================
// Module      : serial_flag_unit
// Description : Digit-serial a - b compare producing zero/negative flags
//               (signed or unsigned). Define SERIAL_FLAG_OVF_EN to add the
//               signed overflow flag output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_flag_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    serial_flag_unit_if.slave bus
);

    localparam int c_NDIG = WIDTH / DIGIT;
    localparam int c_CW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_width_check
            $error("serial_flag_unit: DIGIT must divide WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic             r_carry;
    logic             r_zacc;
    logic [c_CW-1:0]  r_cnt;
    logic             r_zero;
    logic             r_neg;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_sum;
    logic             w_ovf;
    logic             w_fin_zero;
    logic             w_fin_neg;

    // Operands shift right each step, so the active digit is always the low one
    // and on the last step its top bit is the operand sign bit.
    assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, ~r_b[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, r_carry};
    assign w_last     = (r_state == c_RUN) && (r_cnt == c_LAST);
    assign w_accept   = bus.start && (r_state != c_RUN);
    assign w_ovf      = (r_a[DIGIT-1] != r_b[DIGIT-1]) && (w_sum[DIGIT-1] != r_a[DIGIT-1]);
    assign w_fin_zero = r_zacc && (w_sum[DIGIT-1:0] == '0);
    assign w_fin_neg  = r_signed ? (w_sum[DIGIT-1] ^ w_ovf) : ~w_sum[DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  w_next = bus.start ? c_RUN : c_IDLE;
            c_RUN:   w_next = w_last ? c_DONE : c_RUN;
            c_DONE:  w_next = bus.start ? c_RUN : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_RUN:   w_busy = 1'b1;
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_carry  <= 1'b1;
            r_zacc   <= 1'b1;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_signed <= bus.signed_cmp;
            r_carry  <= 1'b1;
            r_zacc   <= 1'b1;
            r_cnt    <= '0;
        end else if (r_state == c_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_sum[DIGIT];
            r_zacc  <= w_fin_zero;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_zero <= w_fin_zero;
                r_neg  <= w_fin_neg;
            end
        end
    end

`ifdef SERIAL_FLAG_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.overflow = r_ovf;
`endif

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.zero     = r_zero;
    assign bus.negative = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_serial_flag_unit.sv
// ============================================================================
// Module      : tb_serial_flag_unit
// Description : Directed self-checking bench for serial_flag_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_flag_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_flag_unit_if #(.WIDTH(32)) bus ();

    serial_flag_unit #(
        .WIDTH (32),
        .DIGIT (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns edges from the start edge until done, and busy-cycle count.
    task automatic wait_done(output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) check("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input logic s);
        @(negedge clk);
        bus.a          = ta;
        bus.b          = tb;
        bus.signed_cmp = s;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    task automatic compare(input logic [31:0] ta, input logic [31:0] tb, input logic s,
                           output int lat, output int bcyc);
        launch(ta, tb, s);
        wait_done(lat, bcyc);
    endtask

    int lat, bcyc, gap, seen_done;

    initial begin
        bus.start      = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_cmp = 1'b0;

        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd0);
        check("rst_neg",  {31'd0, bus.negative}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands
        compare(32'd5, 32'd5, 1'b1, lat, bcyc);
        check("eq_latency", lat, 32'd4);
        check("eq_busy_cycles", bcyc, 32'd4);
        check("eq_busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("eq_zero", {31'd0, bus.zero}, 32'd1);
        check("eq_neg",  {31'd0, bus.negative}, 32'd0);
        @(posedge clk); #1;
        check("eq_done_pulse", {31'd0, bus.done}, 32'd0);
        check("eq_zero_hold", {31'd0, bus.zero}, 32'd1);

        // Signed less-than and its swap
        compare(32'd3, 32'd7, 1'b1, lat, bcyc);
        check("slt_zero", {31'd0, bus.zero}, 32'd0);
        check("slt_neg",  {31'd0, bus.negative}, 32'd1);
        compare(32'd7, 32'd3, 1'b1, lat, bcyc);
        check("sgt_zero", {31'd0, bus.zero}, 32'd0);
        check("sgt_neg",  {31'd0, bus.negative}, 32'd0);

        // Signed overflow case: 0x80000000 - 1
        compare(32'h8000_0000, 32'h0000_0001, 1'b1, lat, bcyc);
        check("sovf_zero", {31'd0, bus.zero}, 32'd0);
        check("sovf_neg",  {31'd0, bus.negative}, 32'd1);
`ifdef SERIAL_FLAG_OVF_EN
        check("sovf_ovf",  {31'd0, bus.overflow}, 32'd1);
`endif

        // Unsigned variants
        compare(32'h8000_0000, 32'h0000_0001, 1'b0, lat, bcyc);
        check("u_ge_neg", {31'd0, bus.negative}, 32'd0);
`ifdef SERIAL_FLAG_OVF_EN
        check("u_ge_ovf", {31'd0, bus.overflow}, 32'd1);
`endif
        compare(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat, bcyc);
        check("u_lt_neg",  {31'd0, bus.negative}, 32'd1);
        check("u_lt_zero", {31'd0, bus.zero}, 32'd0);
`ifdef SERIAL_FLAG_OVF_EN
        check("u_lt_ovf",  {31'd0, bus.overflow}, 32'd0);
`endif

        // start held high with changing operands while busy
        @(negedge clk);
        bus.a = 32'd3; bus.b = 32'd7; bus.signed_cmp = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd7; bus.b = 32'd3; bus.signed_cmp = 1'b0;
        check("hold_mid_zero", {31'd0, bus.zero}, 32'd0);
        wait_done(lat, bcyc);
        bus.start = 1'b0;
        check("hold_latency", lat, 32'd4);
        check("hold_neg", {31'd0, bus.negative}, 32'd1);
        @(posedge clk); #1;
        check("hold_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Back-to-back start during DONE
        compare(32'd1, 32'd2, 1'b0, lat, bcyc);
        check("b2b_first_neg", {31'd0, bus.negative}, 32'd1);
        bus.a = 32'd2; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        gap = 1;
        while (bus.done !== 1'b1 && gap < 20) begin
            @(posedge clk); #1;
            gap++;
        end
        check("b2b_gap", gap, 32'd5);
        check("b2b_zero", {31'd0, bus.zero}, 32'd1);
        check("b2b_neg",  {31'd0, bus.negative}, 32'd0);

        // Reset in the second RUN cycle
        launch(32'h10, 32'h20, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_zero", {31'd0, bus.zero}, 32'd0);
        check("arst_neg",  {31'd0, bus.negative}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1;
        end
        check("arst_no_done", seen_done, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        compare(32'd0, 32'd0, 1'b1, lat, bcyc);
        check("post_rst_latency", lat, 32'd4);
        check("post_rst_zero", {31'd0, bus.zero}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_flag_unit.md
Name: serial_flag_unit

Overview:
Multi-cycle compare engine that produces the zero/negative flag pair consumed by the ALU comparer stage. It computes a - b digit-serially, LSB digit first, over several cycles with a start/done handshake. It serves as the low-area alternative to the full-width subtractor flag path, and it also supports the unsigned compare variants.

Parameters:
WIDTH, 32, operand width in bits.
DIGIT, 8, bits processed per cycle. Must divide WIDTH; elaboration fails otherwise.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned compare; latched with start.
busy  output  1  high from the accepted start until done.
done  output  1  one-cycle pulse; flags valid and stable from this cycle.
zero  output  1  a == b.
negative  output  1  a < b (signed or unsigned, per the latched signed_cmp).

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n: asynchronous, active-low.
- Reset values: busy=0, done=0, zero=0, negative=0; internal state IDLE; digit counter 0; carry 1; zero accumulator 1.
- Reset asserted mid-operation aborts immediately to these values. No done pulse is produced for the aborted compare.
- States:
  - IDLE: start=1 at an edge latches a, b and signed_cmp; sets carry=1 and zero accumulator=1; counter=0; goes to RUN with busy=1.
  - RUN: each edge processes digit[counter] as a_dig + ~b_dig + carry. It stores carry-out, clears the zero accumulator if any result bit is 1, and increments the counter.
  - On the edge that processes digit WIDTH/DIGIT-1, the unit updates zero and negative, pulses done=1 and drops busy=0. It then goes to DONE.
  - DONE: lasts exactly one cycle (done=1), then returns to IDLE. start=1 during DONE is accepted as a new request, with the same behaviour as from IDLE.
- Latency: done is high WIDTH/DIGIT edges after the start edge (4 for the default parameters). Throughput: one compare per WIDTH/DIGIT+1 cycles worst case.
- start while busy=1 is ignored; operands are already latched, so input changes have no effect.
- Flag rules:
  - zero = final zero accumulator.
  - Unsigned negative = ~final carry-out (borrow).
  - Signed negative = diff[WIDTH-1] XOR ovf, where ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - The result digit itself is not stored beyond what the flags need.
- zero and negative hold their last values until the done of the next compare. They do not change during RUN.
- done and busy are never both 1.

Optional Feature:
Macro SERIAL_FLAG_OVF_EN.
- Defined: adds output port overflow (1 bit), the signed overflow of a - b. It is updated with the other flags at done, holds between compares, and resets to 0. It is computed even when signed_cmp=0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Equal operands: a=5, b=5, signed_cmp=1, start pulse -> done after 4 edges with zero=1, negative=0; busy high exactly 4 cycles.
2. Signed less-than: a=3, b=7, signed_cmp=1 -> zero=0, negative=1. Swap to a=7, b=3 -> negative=0.
3. Signed overflow: a=0x80000000, b=0x00000001, signed_cmp=1 -> negative=1, zero=0; overflow=1 with SERIAL_FLAG_OVF_EN.
4. Unsigned variant: same a and b, signed_cmp=0 -> negative=0. Then a=0x00000001, b=0xFFFFFFFF, signed_cmp=0 -> negative=1.
5. Handshake rules:
   - start held high continuously with new operands while busy -> ignored; first result is reported.
   - Back-to-back start during the DONE cycle -> second done exactly 5 cycles after the first.
6. Reset mid-run: rst_n low during the 2nd RUN cycle -> busy, done, zero and negative are 0 immediately with no done pulse. After release, a=0, b=0 compare -> zero=1.
